clk_sel_ctrl: RTL
=================

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYC, default 16: consecutive stable cycles required to accept a select request (legal 2..65535).
REQ-002 The block SHALL have parameter QTO_CYC, default 256: quiesce timeout in cycles (legal 2..65535).
REQ-003 The block SHALL have parameter SETTLE_CYC, default 64: post-switch settle cycles (legal 1..65535).
REQ-004 The block SHALL have port clk_100m  in  1  free-running reference clock; all logic runs on it.
REQ-005 The block SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port sel_req  in  1  asynchronous requested clock source (0=100 MHz, 1=125 MHz).
REQ-007 The block SHALL have port hold_ack  in  1  downstream logic quiesced (clk_100m domain).
REQ-008 The block SHALL have port hold_req  out  1  request for downstream logic to stop using the muxed clock.
REQ-009 The block SHALL have port ck_sel  out  1  select driving the BUFGMUX S input.
REQ-010 The block SHALL have port clk_ok  out  1  muxed clock is stable and usable.
REQ-011 The block SHALL have port busy  out  1  switch sequence in progress.
REQ-012 The block SHALL have port timeout_err  out  1  sticky flag: quiesce ended by timeout.
REQ-013 The block SHALL have port sw_cnt  out  8  count of completed switches.

Function
REQ-014 sel_req SHALL pass through a 2-flop synchronizer (sreq) before any use.
REQ-015 The FSM SHALL have the states IDLE, DEBOUNCE, QUIESCE, SWITCH and SETTLE, with one shared 16-bit cycle counter cleared on every state entry.
REQ-016 IDLE: if sreq != ck_sel, the FSM SHALL go to DEBOUNCE; otherwise it SHALL stay.
REQ-017 DEBOUNCE: if sreq == ck_sel on any cycle, the FSM SHALL return to IDLE (glitch rejected, no outputs change); after DEB_CYC consecutive cycles with sreq != ck_sel, it SHALL go to QUIESCE.
REQ-018 QUIESCE: hold_req=1; hold_ack=1 SHALL move the FSM to SWITCH on the next edge; the counter reaching QTO_CYC without hold_ack SHALL move the FSM to SWITCH and set timeout_err.
REQ-019 SWITCH: lasts exactly 1 cycle; ck_sel SHALL invert on the exiting edge, sw_cnt SHALL increment modulo 256 (255->0), and the FSM SHALL go to SETTLE.
REQ-020 SETTLE: hold_req SHALL stay 1 for exactly SETTLE_CYC cycles, after which the FSM SHALL go to IDLE.
REQ-021 hold_req SHALL be 1 exactly in QUIESCE, SWITCH and SETTLE; busy SHALL be 1 in every state except IDLE; clk_ok SHALL be 1 exactly in IDLE and DEBOUNCE.
REQ-022 All outputs SHALL be registered and glitch-free; ck_sel SHALL change only on the SWITCH exit edge.
REQ-023 sreq changes during QUIESCE, SWITCH or SETTLE SHALL be ignored and re-evaluated only in IDLE; a reverse request SHALL run a full new sequence.
REQ-024 With hold_ack held at 1, ck_sel SHALL toggle on the (DEB_CYC+5)th rising clk_100m edge after a sel_req change that meets setup.
REQ-025 hold_ack while not in QUIESCE SHALL be ignored.

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, ck_sel=0, hold_req=0, busy=0, clk_ok=0, timeout_err=0, sw_cnt=0, synchronizer=0, counter=0.
REQ-027 clk_ok SHALL rise on the first clk_100m edge after reset_n deassertion.
REQ-028 A reset asserted mid-sequence SHALL abort the sequence, with no partial sw_cnt or timeout_err update.
REQ-029 timeout_err SHALL be cleared only by reset.

Configuration
REQ-030 With CLK_SEL_CTRL_TIMEOUT_EN defined, the QUIESCE timeout of REQ-018 SHALL be active.
REQ-031 Without CLK_SEL_CTRL_TIMEOUT_EN, QUIESCE SHALL wait indefinitely for hold_ack, timeout_err SHALL be tied to 0, and QTO_CYC SHALL be unused.

Verification
REQ-032 Test: reset, sel_req=0 -> ck_sel=0, clk_ok=1 one edge after release, busy=0, sw_cnt=0.
REQ-033 Test: hold_ack=1, sel_req 0->1, defaults -> ck_sel=1 on edge 21, hold_req high 1+1+64 cycles, sw_cnt=1, timeout_err=0.
REQ-034 Test: sel_req 10-cycle pulse with DEB_CYC=16 -> no hold_req, ck_sel unchanged, sw_cnt=0.
REQ-035 Test: hold_ack=0, TIMEOUT_EN defined -> ck_sel toggles after 256 QUIESCE cycles, timeout_err=1 sticky; without the macro -> FSM stays in QUIESCE until hold_ack=1.
REQ-036 Test: sel_req toggled back during SETTLE -> first switch completes, then a second full sequence runs, ck_sel=0, sw_cnt=2.
REQ-037 Test: reset_n pulsed low during QUIESCE -> ck_sel=0, hold_req=0, sw_cnt unchanged from reset value 0.

Source files
------------

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: glitch-safe BUFGMUX select sequencer (debounce, quiesce, switch, settle).
// Define CLK_SEL_CTRL_TIMEOUT_EN to enable the quiesce timeout and the sticky timeout_err flag.
module clk_sel_ctrl #(
  parameter int unsigned DEB_CYC    = 16,
  parameter int unsigned QTO_CYC    = 256,
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic       clk_100m,
  input  logic       reset_n,
  input  logic       sel_req,
  input  logic       hold_ack,
  output logic       hold_req,
  output logic       ck_sel,
  output logic       clk_ok,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] sw_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    QUIESCE  = 3'd2,
    SWITCH   = 3'd3,
    SETTLE   = 3'd4
  } state_t;

  localparam logic [15:0] DEB_LAST    = 16'(DEB_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        sreq_q, sreq_d;
  logic        ck_sel_q, ck_sel_d;
  logic        hold_req_q, hold_req_d;
  logic        busy_q, busy_d;
  logic        clk_ok_q, clk_ok_d;
  logic [7:0]  sw_cnt_q, sw_cnt_d;

`ifdef CLK_SEL_CTRL_TIMEOUT_EN
  localparam logic [15:0] QTO_LAST = 16'(QTO_CYC - 1);
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    sync1_d  = sel_req;
    sreq_d   = sync1_q;
    state_d  = state_q;
    ck_sel_d = ck_sel_q;
    sw_cnt_d = sw_cnt_q;
`ifdef CLK_SEL_CTRL_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (sreq_q != ck_sel_q) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (sreq_q == ck_sel_q)    state_d = IDLE;
        else if (cnt_q == DEB_LAST) state_d = QUIESCE;
      end
      QUIESCE: begin
        // An acknowledge on the last allowed cycle wins over the timeout.
        if (hold_ack) begin
          state_d = SWITCH;
        end
`ifdef CLK_SEL_CTRL_TIMEOUT_EN
        else if (cnt_q == QTO_LAST) begin
          state_d   = SWITCH;
          timeout_d = 1'b1;
        end
`endif
      end
      SWITCH: begin
        state_d  = SETTLE;
        ck_sel_d = ~ck_sel_q;
        sw_cnt_d = sw_cnt_q + 8'd1;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared counter restarts on every state entry and idles at zero.
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    else                                       cnt_d = cnt_q + 16'd1;

    // Outputs are decoded from the next state so the registers track the state exactly.
    hold_req_d = (state_d == QUIESCE) || (state_d == SWITCH) || (state_d == SETTLE);
    busy_d     = (state_d != IDLE);
    clk_ok_d   = (state_d == IDLE) || (state_d == DEBOUNCE);
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      sreq_q     <= 1'b0;
      ck_sel_q   <= 1'b0;
      hold_req_q <= 1'b0;
      busy_q     <= 1'b0;
      clk_ok_q   <= 1'b0;
      sw_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sreq_q     <= sreq_d;
      ck_sel_q   <= ck_sel_d;
      hold_req_q <= hold_req_d;
      busy_q     <= busy_d;
      clk_ok_q   <= clk_ok_d;
      sw_cnt_q   <= sw_cnt_d;
    end
  end

`ifdef CLK_SEL_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= timeout_d;
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign hold_req = hold_req_q;
  assign ck_sel   = ck_sel_q;
  assign clk_ok   = clk_ok_q;
  assign busy     = busy_q;
  assign sw_cnt   = sw_cnt_q;

endmodule
